// File: rtl/uart_resp_pkg.sv
// Shared types and constants for the UART test-responder cluster.
package uart_resp_pkg;
  localparam int BYTE_W = 8;

  localparam logic [7:0] CMD_SAMPLER     = 8'h21;
  localparam logic [7:0] CMD_SAMPLE_READ = 8'h22;
  localparam logic [7:0] CMD_REPLAYER    = 8'h71;
  localparam logic [7:0] CMD_REPLY_CNT   = 8'h72;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_RX = 3'd1,
    SEND    = 3'd2,
    WAIT_TX = 3'd3,
    DONE    = 3'd4
  } resp_state_t;
endpackage

// File: rtl/byte_sender.sv
// Responder FSM shared by replayer and reply_cnt: waits for one received byte,
// then streams either that byte (echo) or the sequence 0..N-1 (count mode).
module byte_sender
  import uart_resp_pkg::*;
#(
  parameter int W          = BYTE_W,
  parameter bit COUNT_MODE = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_activate,
  input  logic         i_rx_ready,
  input  logic [W-1:0] i_rx_data,
  input  logic         i_tx_active,
  input  logic         i_tx_done,
  output logic         o_tx_start,
  output logic [W-1:0] o_tx_data,
  output logic         o_done
);
  resp_state_t  r_state;
  logic [W-1:0] r_byte;
  logic [W-1:0] r_len;
  logic [W-1:0] r_idx;
  logic [W-1:0] r_tx_data;
  logic         r_tx_start;
  logic         r_done;

  logic [W-1:0] w_next_byte;
  logic [W-1:0] w_rx_len;
  logic [W-1:0] w_rx_first;
  logic         w_more;

  always_comb begin
    w_next_byte = COUNT_MODE ? r_idx : r_byte;
    w_rx_len    = COUNT_MODE ? i_rx_data : W'(1);
    w_rx_first  = COUNT_MODE ? W'(0) : i_rx_data;
    w_more      = (r_idx != r_len);
  end

  // r_idx counts bytes already handed to the UART; the stream ends when it reaches r_len.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_byte     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
    end else if (!i_activate) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          r_done  <= 1'b0;
          r_state <= WAIT_RX;
        end
        WAIT_RX: begin
          if (i_rx_ready) begin
            r_byte  <= i_rx_data;
            r_len   <= w_rx_len;
            r_idx   <= '0;
            r_state <= SEND;
            if ((w_rx_len != '0) && !i_tx_active) begin
              r_tx_start <= 1'b1;
              r_tx_data  <= w_rx_first;
              r_idx      <= W'(1);
              r_state    <= WAIT_TX;
            end
          end
        end
        SEND: begin
          if (!w_more) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (!i_tx_active) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_next_byte;
            r_idx      <= r_idx + W'(1);
            r_state    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            if (!w_more) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (!i_tx_active) begin
              r_tx_start <= 1'b1;
              r_tx_data  <= w_next_byte;
              r_idx      <= r_idx + W'(1);
            end else begin
              r_state <= SEND;
            end
          end
        end
        DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_done     = r_done;
endmodule

// File: rtl/fake_adc.sv
// Synthetic ADC: free-running sawtooth advanced once per enabled cycle.
module fake_adc
  import uart_resp_pkg::*;
#(
  parameter int W = BYTE_W
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_en,
  output logic [W-1:0] o_data
);
  logic [W-1:0] r_data;

  // Natural wrap from all-ones back to zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= r_data + W'(1);
    end
  end

  assign o_data = r_data;
endmodule

// File: rtl/replayer.sv
// One-byte echo responder.
module replayer
  import uart_resp_pkg::*;
#(
  parameter int W = BYTE_W
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_activate,
  input  logic         i_rx_ready,
  input  logic [W-1:0] i_rx_data,
  input  logic         i_tx_active,
  input  logic         i_tx_done,
  output logic         o_tx_start,
  output logic [W-1:0] o_tx_data,
  output logic         o_done
);
  byte_sender #(.W(W), .COUNT_MODE(1'b0)) u_sender (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_activate (i_activate),
    .i_rx_ready (i_rx_ready),
    .i_rx_data  (i_rx_data),
    .i_tx_active(i_tx_active),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_done     (o_done)
  );
endmodule

// File: rtl/reply_cnt.sv
// Count-sequence responder: received byte N selects the stream 0..N-1.
module reply_cnt
  import uart_resp_pkg::*;
#(
  parameter int W = BYTE_W
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_activate,
  input  logic         i_rx_ready,
  input  logic [W-1:0] i_rx_data,
  input  logic         i_tx_active,
  input  logic         i_tx_done,
  output logic         o_tx_start,
  output logic [W-1:0] o_tx_data,
  output logic         o_done
);
  byte_sender #(.W(W), .COUNT_MODE(1'b1)) u_sender (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_activate (i_activate),
    .i_rx_ready (i_rx_ready),
    .i_rx_data  (i_rx_data),
    .i_tx_active(i_tx_active),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_done     (o_done)
  );
endmodule

// File: rtl/uart_test_responders.sv
// UART test-responder cluster: fake ADC, echo and count responders, and the
// priority TX mux that hands the shared transmitter to the active responder.
module uart_test_responders
  import uart_resp_pkg::*;
#(
  parameter int DATA_WIDTH = BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adc_en,
  output logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  tx_active,
  input  logic                  tx_done,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  replayer_activate,
  output logic                  replayer_done,
  input  logic                  reply_cnt_activate,
  output logic                  reply_cnt_done
);
  logic                  w_rp_start;
  logic [DATA_WIDTH-1:0] w_rp_data;
  logic                  w_rc_start;
  logic [DATA_WIDTH-1:0] w_rc_data;

  fake_adc #(.W(DATA_WIDTH)) u_fake_adc (
    .i_clk    (clk),
    .i_reset_n(reset),
    .i_en     (adc_en),
    .o_data   (adc_data)
  );

  replayer #(.W(DATA_WIDTH)) u_replayer (
    .i_clk      (clk),
    .i_reset_n  (reset),
    .i_activate (replayer_activate),
    .i_rx_ready (rx_ready),
    .i_rx_data  (rx_data),
    .i_tx_active(tx_active),
    .i_tx_done  (tx_done),
    .o_tx_start (w_rp_start),
    .o_tx_data  (w_rp_data),
    .o_done     (replayer_done)
  );

  reply_cnt #(.W(DATA_WIDTH)) u_reply_cnt (
    .i_clk      (clk),
    .i_reset_n  (reset),
    .i_activate (reply_cnt_activate),
    .i_rx_ready (rx_ready),
    .i_rx_data  (rx_data),
    .i_tx_active(tx_active),
    .i_tx_done  (tx_done),
    .o_tx_start (w_rc_start),
    .o_tx_data  (w_rc_data),
    .o_done     (reply_cnt_done)
  );

  // Replayer has priority when both responders are activated.
  always_comb begin
    if (replayer_activate) begin
      tx_start = w_rp_start;
      tx_data  = w_rp_data;
    end else if (reply_cnt_activate) begin
      tx_start = w_rc_start;
      tx_data  = w_rc_data;
    end else begin
      tx_start = 1'b0;
      tx_data  = '0;
    end
  end
endmodule

// File: tb/tb_uart_test_responders.sv
// Scoreboard bench: expected TX bytes are queued at stimulus time and popped
// by a monitor on each tx_start; a simple UART model answers with tx_done.
module tb_uart_test_responders;
  logic       clk = 1'b0;
  logic       reset, adc_en, rx_ready;
  logic [7:0] rx_data, adc_data, tx_data;
  logic       tx_active, tx_done, tx_start;
  logic       replayer_activate, replayer_done, reply_cnt_activate, reply_cnt_done;
  logic       uart_busy = 1'b0;
  logic       ext_busy  = 1'b0;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         uart_len = 4;
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic       prev_start = 1'b0;

  assign tx_active = uart_busy | ext_busy;

  uart_test_responders #(.DATA_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .adc_en            (adc_en),
    .adc_data          (adc_data),
    .rx_ready          (rx_ready),
    .rx_data           (rx_data),
    .tx_active         (tx_active),
    .tx_done           (tx_done),
    .tx_start          (tx_start),
    .tx_data           (tx_data),
    .replayer_activate (replayer_activate),
    .replayer_done     (replayer_done),
    .reply_cnt_activate(reply_cnt_activate),
    .reply_cnt_done    (reply_cnt_done)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic done_of(input bit which);
    return which ? reply_cnt_done : replayer_done;
  endfunction

  // Monitor: every tx_start pops one expected byte.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      chk("start_while_busy", int'(tx_active), 0);
      chk("start_back_to_back", int'(prev_start), 0);
      start_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx_start: got data %0d, no byte expected (cycle %0d)", tx_data, cyc);
      end else begin
        chk("tx_data", int'(tx_data), int'(exp_q.pop_front()));
      end
    end
    prev_start = tx_start;
  end

  // UART model: busy for uart_len cycles after a start, then a one-cycle tx_done.
  initial begin
    int len;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        len = uart_len;
        @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1;
        uart_busy = 1'b0;
        tx_done   = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic send_rx(input logic [7:0] b, output int k);
    rx_ready = 1'b1;
    rx_data  = b;
    k        = cyc;
    step();
    rx_ready = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int exp_cyc, input string name);
    int t = 0;
    sample();
    while (done_of(which) !== 1'b1 && t < 600) begin
      step();
      sample();
      t++;
    end
    chk(name, cyc, exp_cyc);
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    sample();
    while (start_q.size() < n && t < 300) begin
      step();
      sample();
      t++;
    end
    chk("starts_seen", start_q.size(), n);
  endtask

  task automatic wait_uart_idle();
    int t = 0;
    while ((uart_busy || tx_done) && t < 500) begin
      step();
      t++;
    end
    step();
  endtask

  task automatic drop_all();
    step();
    replayer_activate  = 1'b0;
    reply_cnt_activate = 1'b0;
    step();
    wait_uart_idle();
  endtask

  initial begin
    int         k, m, n_cnt, adc_model;
    bit         which;
    logic [7:0] b;

    // Reset with everything else asserted.
    reset = 1'b0; adc_en = 1'b1; rx_ready = 1'b1; rx_data = 8'h72;
    replayer_activate = 1'b1; reply_cnt_activate = 1'b1;
    repeat (3) step();
    sample();
    chk("rst_adc_data", int'(adc_data), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_replayer_done", int'(replayer_done), 0);
    chk("rst_reply_cnt_done", int'(reply_cnt_done), 0);
    step();
    reset = 1'b1; adc_en = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    replayer_activate = 1'b0; reply_cnt_activate = 1'b0;
    step();

    // Sawtooth across the wrap, then hold, then a random enable pattern.
    adc_en = 1'b1;
    for (int i = 0; i < 257; i++) begin
      sample();
      chk("adc_ramp", int'(adc_data), i % 256);
      step();
    end
    adc_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("adc_hold", int'(adc_data), 1);
      step();
    end
    adc_model = 1;
    for (int i = 0; i < 40; i++) begin
      adc_en = 1'($urandom_range(0, 1));
      sample();
      chk("adc_random", int'(adc_data), adc_model);
      step();
      if (adc_en) adc_model = (adc_model + 1) % 256;
    end
    adc_en = 1'b0;

    // Replayer echo; the strobe in the activation cycle is the command byte.
    uart_len = 48;
    replayer_activate = 1'b1; rx_ready = 1'b1; rx_data = 8'h71;
    step();
    rx_ready = 1'b0;
    step();
    exp_q.push_back(8'hA5);
    send_rx(8'hA5, k);
    sample();
    chk("rep_start_k1", int'(tx_start), 1);
    chk("rep_data_k1", int'(tx_data), 8'hA5);
    wait_done(1'b0, k + 51, "rep_done_cycle");
    for (int i = 0; i < 3; i++) begin
      step();
      sample();
      chk("rep_done_held", int'(replayer_done), 1);
    end
    step();
    replayer_activate = 1'b0;
    sample();
    step();
    sample();
    chk("rep_done_clear", int'(replayer_done), 0);
    wait_uart_idle();

    // reply_cnt N=3.
    uart_len = 4;
    reply_cnt_activate = 1'b1;
    step(); step();
    start_q.delete();
    for (int j = 0; j < 3; j++) exp_q.push_back(8'(j));
    send_rx(8'h03, k);
    wait_done(1'b1, k + 3 * (uart_len + 2) + 1, "cnt3_done_cycle");
    chk("cnt3_nstarts", start_q.size(), 3);
    for (int j = 0; j < start_q.size(); j++)
      chk("cnt3_start_cycle", start_q[j], k + 1 + j * (uart_len + 2));
    drop_all();

    // reply_cnt N=0.
    reply_cnt_activate = 1'b1;
    step(); step();
    start_q.delete();
    send_rx(8'h00, k);
    wait_done(1'b1, k + 2, "cnt0_done_cycle");
    chk("cnt0_nstarts", start_q.size(), 0);
    drop_all();

    // Busy transmitter holds off the replayer start.
    ext_busy = 1'b1;
    replayer_activate = 1'b1;
    step(); step();
    start_q.delete();
    exp_q.push_back(8'h3C);
    send_rx(8'h3C, k);
    repeat (5) step();
    sample();
    chk("busy_withheld", start_q.size(), 0);
    step();
    ext_busy = 1'b0;
    m = cyc;
    wait_done(1'b0, m + uart_len + 3, "busy_done_cycle");
    chk("busy_nstarts", start_q.size(), 1);
    if (start_q.size() > 0) chk("busy_start_cycle", start_q[0], m + 1);
    drop_all();

    // Abort by dropping activate between reply_cnt bytes.
    uart_len = 6;
    reply_cnt_activate = 1'b1;
    step(); step();
    start_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    send_rx(8'h05, k);
    wait_starts(2);
    step();
    reply_cnt_activate = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      sample();
      chk("abort_done_low", int'(reply_cnt_done), 0);
    end
    chk("abort_nstarts", start_q.size(), 2);
    wait_uart_idle();

    // Abort by reset mid-transfer with activate still high.
    reply_cnt_activate = 1'b1;
    step(); step();
    start_q.delete();
    exp_q.push_back(8'h00);
    send_rx(8'h04, k);
    wait_starts(1);
    step();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      sample();
      chk("rst_abort_done_low", int'(reply_cnt_done), 0);
    end
    chk("rst_abort_nstarts", start_q.size(), 1);
    drop_all();

    // Both activated: replayer owns the transmitter.
    uart_len = 3;
    replayer_activate = 1'b1; reply_cnt_activate = 1'b1;
    step(); step();
    start_q.delete();
    exp_q.push_back(8'h5A);
    send_rx(8'h5A, k);
    wait_done(1'b0, k + uart_len + 3, "both_rep_done");
    chk("both_nstarts", start_q.size(), 1);
    drop_all();

    // Randomised transactions against the closed-form reference.
    for (int it = 0; it < 8; it++) begin
      which    = 1'($urandom_range(0, 1));
      uart_len = $urandom_range(1, 5);
      if (which) begin
        n_cnt = $urandom_range(0, 6);
        b     = 8'(n_cnt);
        for (int j = 0; j < n_cnt; j++) exp_q.push_back(8'(j));
        reply_cnt_activate = 1'b1;
      end else begin
        n_cnt = 1;
        b     = 8'($urandom);
        exp_q.push_back(b);
        replayer_activate = 1'b1;
      end
      rx_ready = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      step();
      rx_ready = 1'b0;
      step();
      send_rx(b, k);
      wait_done(which, (n_cnt == 0) ? k + 2 : k + n_cnt * (uart_len + 2) + 1,
                which ? "rand_cnt_done" : "rand_rep_done");
      chk("rand_queue_drained", exp_q.size(), 0);
      drop_all();
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
